inst_rom_arb: RTL
=================

INST_ROM_ARB -- requirements
Module: inst_rom_arb

Interface
REQ-001 Parameter DBG_WAIT_MAX, default 4, meaning: cycles a blocked debug request waits before it is forced ahead of the CPU (range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset: one clock, synchronous, active-high (`RstEnable).
REQ-004 cpu_ce  input  1  CPU fetch request (`ChipEnable = request).
REQ-005 cpu_addr  input  `InstAddressBus  CPU fetch byte address (PC).
REQ-006 cpu_stall  output  1  CPU request present but not granted this cycle.
REQ-007 cpu_inst  output  `InstDataBus  fetched instruction for CPU.
REQ-008 cpu_rvalid  output  1  cpu_inst valid this cycle.
REQ-009 dbg_req  input  1  debug/loader read request; held until dbg_gnt.
REQ-010 dbg_addr  input  `InstAddressBus  debug read byte address.
REQ-011 dbg_gnt  output  1  debug request accepted this cycle.
REQ-012 dbg_rdata  output  `InstDataBus  debug read data.
REQ-013 dbg_rvalid  output  1  dbg_rdata/dbg_err valid this cycle.
REQ-014 dbg_err  output  1  accepted debug address was misaligned.
REQ-015 rom_ce  output  1  chip enable to instruction ROM.
REQ-016 rom_addr  output  `InstAddressBus  byte address to instruction ROM.
REQ-017 rom_inst  input  `InstDataBus  combinational ROM read data.

Function
REQ-018 Grant decided combinationally in cycle T; at most one port granted per cycle.
REQ-019 Priority: CPU wins unless wait_cnt == DBG_WAIT_MAX and dbg_req high, then debug wins.
REQ-020 wait_cnt: +1 per cycle with dbg_req & ~dbg_gnt, saturating at DBG_WAIT_MAX; cleared on dbg_gnt or dbg_req low.
REQ-021 cpu_stall = cpu_ce & ~(CPU granted); combinational, same cycle.
REQ-022 Granted port drives rom_addr; rom_ce = `ChipEnable only when a grant exists and address is valid; else `ChipDisable, rom_addr = `ZeroWord.
REQ-023 CPU address low bits [1:0] ignored (word fetch); debug address with [1:0] != 0 is misaligned.
REQ-024 Misaligned debug grant: rom_ce disabled; in T+1 dbg_rvalid=1, dbg_err=1, dbg_rdata=`ZeroWord.
REQ-025 rom_inst sampled at end of T into response register; owner FSM (IDLE/CPU/DBG) registered from grant routes it.
REQ-026 Latency exactly 1: *_rvalid high in T+1 for one cycle per grant; back-to-back grants give back-to-back rvalid.
REQ-027 cpu_inst/dbg_rdata hold last captured value when rvalid low.
REQ-028 Owner FSM: IDLE->CPU on CPU grant, ->DBG on debug grant, ->IDLE on no grant; any state reachable from any state each cycle.
REQ-029 Simultaneous requests with wait_cnt < DBG_WAIT_MAX: CPU granted, cpu_stall=0, dbg_gnt=0, wait_cnt increments.

Reset
REQ-030 rst high: owner=IDLE, wait_cnt=0, cpu_rvalid=dbg_rvalid=dbg_err=0, cpu_inst=dbg_rdata=`ZeroWord.
REQ-031 During rst: no grants, rom_ce=`ChipDisable, cpu_stall=0, dbg_gnt=0.
REQ-032 Reset in cycle T+1 after a grant in T drops that response; no rvalid after reset release without new grant.

Structure
REQ-033 DBG_WAIT_MAX default, owner-state encodings and arbiter widths live in shared define.v; bus widths reuse `InstAddressBus/`InstDataBus.
REQ-034 Single flat module; no sub-modules; instantiated between the CPU top and inst_rom at SoC level.

Verification
REQ-035 CPU only, cpu_addr=0x00000004, ROM word1=0x34011100 -> rom_ce=1, cpu_stall=0; next cycle cpu_rvalid=1, cpu_inst=0x34011100.
REQ-036 Debug only, dbg_addr=0x00000008, word2=0x34020020 -> dbg_gnt=1 same cycle; next cycle dbg_rvalid=1, dbg_rdata=0x34020020, dbg_err=0.
REQ-037 Both held continuously, DBG_WAIT_MAX=4 -> CPU granted 4 cycles, debug granted 5th with cpu_stall=1, CPU resumes 6th.
REQ-038 dbg_addr=0x00000006 -> dbg_gnt=1, rom_ce=0; next cycle dbg_rvalid=1, dbg_err=1, dbg_rdata=0.
REQ-039 rst asserted in cycle after CPU grant -> cpu_rvalid=0, cpu_inst=0, wait_cnt=0 after release.

Source files
------------

// File: rtl/inst_rom_arb_pkg.sv
// inst_rom_arb_pkg: shared constants and types for the instruction ROM arbiter.
//   ADDR_W / DATA_W   instruction address and data bus widths
//   WAIT_W            width of the debug wait counter (holds 1..15)
//   owner_e           owner FSM encoding (who the ROM response belongs to)
//   addr_misaligned   true when a byte address is not word aligned
package inst_rom_arb_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int WAIT_W           = 4;
    localparam int DBG_WAIT_MAX_DEF = 4;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_arb_if.sv
// inst_rom_arb_if: bundles the CPU fetch port, debug read port and ROM port.
//   slave  : arbiter view (takes requests and ROM data, drives grants/responses/ROM)
//   master : environment view (CPU, debug loader and ROM together)
interface inst_rom_arb_if;
    import inst_rom_arb_pkg::*;

    logic              cpu_ce;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_inst;
    logic              cpu_rvalid;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_rvalid;
    logic              dbg_err;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_inst;

    modport slave (
        input  cpu_ce, cpu_addr, dbg_req, dbg_addr, rom_inst,
        output cpu_stall, cpu_inst, cpu_rvalid,
        output dbg_gnt, dbg_rdata, dbg_rvalid, dbg_err,
        output rom_ce, rom_addr
    );

    modport master (
        output cpu_ce, cpu_addr, dbg_req, dbg_addr, rom_inst,
        input  cpu_stall, cpu_inst, cpu_rvalid,
        input  dbg_gnt, dbg_rdata, dbg_rvalid, dbg_err,
        input  rom_ce, rom_addr
    );

endinterface

// File: rtl/inst_rom_arb.sv
// inst_rom_arb: shares one combinational instruction ROM between the CPU fetch
// port and a debug/loader read port. Grant is decided in the request cycle;
// the response appears exactly one cycle later on the owning port.
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : inst_rom_arb_if.slave (CPU port, debug port, ROM port)
// Parameter DBG_WAIT_MAX (1..15): cycles a blocked debug request waits before
// it is forced ahead of the CPU.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int DBG_WAIT_MAX = DBG_WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    inst_rom_arb_if.slave   bus
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DBG_WAIT_MAX);

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
    endfunction

    owner_e            owner_q, owner_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dbg_force, cpu_grant, dbg_grant, dbg_mis;
    logic [DATA_W-1:0] cpu_inst_p1, dbg_rdata_p1;
    logic              dbg_err_p1;

    // Stage 0: combinational arbitration and ROM drive
    always_comb begin
        dbg_force = bus.dbg_req && (wait_cnt == WAIT_MAX);
        cpu_grant = !rst && bus.cpu_ce && !dbg_force;
        dbg_grant = !rst && bus.dbg_req && !cpu_grant;
        dbg_mis   = addr_misaligned(bus.dbg_addr);

        bus.cpu_stall = !rst && bus.cpu_ce && !cpu_grant;
        bus.dbg_gnt   = dbg_grant;

        bus.rom_ce   = CHIP_DISABLE;
        bus.rom_addr = ZERO_WORD;
        if (cpu_grant) begin
            // Word fetch: low address bits are dropped rather than checked.
            bus.rom_ce   = CHIP_ENABLE;
            bus.rom_addr = bus.cpu_addr & ~ADDR_W'(3);
        end else if (dbg_grant && !dbg_mis) begin
            bus.rom_ce   = CHIP_ENABLE;
            bus.rom_addr = bus.dbg_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!bus.dbg_req || dbg_grant) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    // Stage 1: response capture; each port keeps its last captured word
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_inst_p1  <= ZERO_WORD;
            dbg_rdata_p1 <= ZERO_WORD;
            dbg_err_p1   <= 1'b0;
        end else begin
            if (cpu_grant) cpu_inst_p1 <= bus.rom_inst;
            if (dbg_grant) dbg_rdata_p1 <= dbg_mis ? ZERO_WORD : bus.rom_inst;
            dbg_err_p1 <= dbg_grant && dbg_mis;
        end
    end

    // Owner FSM: state register
    always_ff @(posedge clk) begin
        if (rst) owner_q <= OWN_IDLE;
        else     owner_q <= owner_d;
    end

    // Owner FSM: next state follows this cycle's grant
    always_comb begin
        owner_d = OWN_IDLE;
        if (cpu_grant)      owner_d = OWN_CPU;
        else if (dbg_grant) owner_d = OWN_DBG;
    end

    // Owner FSM: outputs. Gating with rst drops a response whose grant was
    // in the cycle just before reset, and forces zeroed data while in reset.
    always_comb begin
        bus.cpu_rvalid = !rst && (owner_q == OWN_CPU);
        bus.dbg_rvalid = !rst && (owner_q == OWN_DBG);
        bus.dbg_err    = !rst && (owner_q == OWN_DBG) && dbg_err_p1;
        bus.cpu_inst   = rst ? ZERO_WORD : cpu_inst_p1;
        bus.dbg_rdata  = rst ? ZERO_WORD : dbg_rdata_p1;
    end

endmodule
